twiddle_gen: RTL and testbench
==============================

# twiddle_gen

Streaming twiddle-factor source for the radix-2 DIT FFT datapath. It drives the 12-bit signed Q1.10 twiddle operands of the butterfly complex multiplier, which consumes Re/Im twiddles scaled by 1024 and rounds the product back by 2^10. On a start command for a given stage it emits the N/2 twiddles W_N^k = cos(2πk/N) − j·sin(2πk/N) in butterfly order, over a valid/ready handshake. Twiddle values come from a quarter-wave cosine ROM with quadrant folding.

## Interface
Parameters:
- LOG2N, 8, log2 of the FFT size N (3..15).
- TW_W, 12, twiddle width, signed, Q1.10 (1.0 = 1024).

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle request to generate one stage's twiddles.
- i_stage  in  4  stage index s, sampled with i_start; valid range 0..LOG2N−1.
- o_re  out  TW_W  twiddle real part, signed.
- o_im  out  TW_W  twiddle imaginary part, signed.
- o_valid  out  1  o_re/o_im hold a twiddle.
- i_ready  in  1  consumer accepts the word when o_valid && i_ready.
- o_last  out  1  qualifies the final (N/2-th) word of the stage.
- o_busy  out  1  a stage is in progress.
- o_err  out  1  one-cycle pulse: i_start had i_stage ≥ LOG2N.

## Operation
- States:
  - IDLE: waits for a start.
    - i_start with a valid stage: latch s, clear j, go to RUN.
    - i_start with an invalid stage: pulse o_err, stay in IDLE.
  - RUN: issues j = 0..N/2−1 into the pipeline, one per enabled cycle. After issuing j = N/2−1, go to DRAIN.
  - DRAIN: waits until the word carrying o_last is handshaken, then returns to IDLE.
- i_start is ignored outside IDLE. No o_err is raised in that case.
- Exponent: k = (j mod 2^s) · 2^(LOG2N−1−s), with 0 ≤ k < N/2.
- ROM: C[i] = round(1024·cos(2πi/N)) for i = 0..N/4. C[0] = 1024, C[N/4] = 0.
- Quadrant folding, with Q = N/4:
  - k ≤ Q: Re = C[k], Im = −C[Q−k].
  - k > Q: Re = −C[N/2−k], Im = −C[k−Q].
- Widths:
  - ROM entries are 11-bit unsigned.
  - Negation is performed in TW_W-bit signed arithmetic.
  - Results lie in [−1024, 1024]; no saturation is needed.
- o_busy is high from the cycle after an accepted start until the cycle after the o_last handshake.

## Timing
- Pipeline has 3 stages: exponent/address register → synchronous ROM read → fold/negate output register.
- Pipeline enable: en = !o_valid || i_ready. All stages stall together, so there are no bubbles and no drops.
- Latency: start accepted at cycle t → first o_valid at t+3 with i_ready held high. Thereafter one word per cycle.
- Backpressure: while o_valid && !i_ready, o_re, o_im and o_last stay stable.
- o_last is asserted only together with o_valid.
- Back-to-back stages: a new i_start is accepted no earlier than the cycle after o_busy falls.
- Reset values (rst_n low at an edge): state IDLE; o_valid, o_last, o_busy, o_err = 0; o_re, o_im = 0; counters cleared. This holds when reset occurs mid-stage: the pipeline is flushed and no partial stage resumes.
- i_ready is don't-care while o_valid is low.

## Structure
- Shared package fft_pkg: TW_W = 12, TW_FRAC = 10, default LOG2N, the state enum (IDLE/RUN/DRAIN), and the Q1.10 ONE = 1024 constant. The complex multiplier's operand widths reference the same constants.
- Sub-module twiddle_rom:
  - Quarter-wave cosine table of depth N/4+1.
  - Synchronous read with an enable input.
  - Contents generated at elaboration from LOG2N.
- twiddle_gen holds the FSM, the j counter, k/quadrant computation, the fold/negate stage, and the handshake.

## Test plan
1. LOG2N=3, start stage 2, i_ready=1 → at t+3..t+6 words (1024,0), (724,−724), (0,−1024), (−724,−724); o_last on the 4th word; o_busy falls the next cycle.
2. LOG2N=3, stage 0 → four words of (1024,0); stage 1 → (1024,0), (0,−1024), (1024,0), (0,−1024).
3. Stage 2 with i_ready toggled randomly (including low for 5 cycles mid-stream) → the same 4 words in the same order, each held stable while stalled; no duplicates or drops.
4. i_start with i_stage=3 at LOG2N=3 → o_err pulses for 1 cycle; o_busy stays 0; no o_valid. A second i_start during RUN is ignored.
5. rst_n low for 1 cycle after the 2nd word of stage 2 → all outputs 0 the next cycle. A fresh start then yields the full sequence from (1024,0).
6. LOG2N=8, all stages with random backpressure → every word matches the cos/−sin golden model within ±0 LSB; exactly 128 words per stage, last flagged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: Q1.10 twiddle format, default size,
// sequencer state encoding and the cosine table generator.
package fft_pkg;

    localparam int TW_W      = 12;
    localparam int TW_FRAC   = 10;
    localparam int LOG2N_DEF = 8;
    localparam int ONE       = 1 << TW_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // round(ONE * cos(2*pi*i/N)); only used for 0 <= i <= N/4,
    // where the value is non-negative.
    function automatic int cos_q(input int i, input int log2n);
        real a;
        a = 2.0 * 3.14159265358979323846 * real'(i)
            / real'(1 << log2n);
        return $rtoi(real'(ONE) * $cos(a) + 0.5);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table, depth N/4+1, two synchronous read ports.
// Ports: clk, en (read enable), addr_a/addr_b -> data_a/data_b (11b).
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int AW    = LOG2N - 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic [10:0]   data_a,
    output logic [10:0]   data_b
);

    localparam int DEPTH = (1 << (LOG2N - 2)) + 1;

    logic [10:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = 11'(cos_q(g, LOG2N));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// Streams the N/2 twiddles W_N^k of one radix-2 stage over valid/ready.
// Ports: i_start/i_stage request, o_re/o_im/o_valid/o_last/i_ready
// stream, o_busy stage in progress, o_err bad-stage pulse.
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int TW_W  = fft_pkg::TW_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [3:0]             i_stage,
    output logic signed [TW_W-1:0] o_re,
    output logic signed [TW_W-1:0] o_im,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int JW = LOG2N - 1;
    localparam logic [JW-1:0] JMAX = JW'((1 << JW) - 1);
    localparam logic [JW-1:0] QTR  = JW'(1 << (LOG2N - 2));

    state_t        state, nxt;
    logic [3:0]    s;
    logic [JW-1:0] j;
    logic          en, issue, last_j, start_ok;

    logic [JW-1:0] msk, k, addr_a, addr_b;
    logic          hi;

    logic          v1, l1, h1, v2, l2, h2;
    logic [JW-1:0] a1, b1;
    logic [10:0]   da, db;
    logic signed [TW_W-1:0] ra, rb;

    // One enable for the whole pipe: it only moves when the output
    // slot is free or being consumed.
    assign en       = !o_valid || i_ready;
    assign start_ok = i_start && (int'(i_stage) < LOG2N);
    assign issue    = (state == RUN) && en;
    assign last_j   = (j == JMAX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start_ok) nxt = RUN;
            RUN:     if (issue && last_j) nxt = DRAIN;
            DRAIN:   if (o_valid && o_last && i_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s <= '0;
            j <= '0;
        end else if (state == IDLE && start_ok) begin
            s <= i_stage;
            j <= '0;
        end else if (issue) begin
            j <= j + JW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) o_err <= 1'b0;
        else        o_err <= (state == IDLE) && i_start && !start_ok;
    end

    // k = (j mod 2^s) * 2^(LOG2N-1-s); fold k into the first quadrant.
    // For k > Q, N/2-k equals -k modulo 2^JW.
    always_comb begin
        msk    = JW'((32'd1 << s) - 32'd1);
        k      = JW'(32'(j & msk) << (JW - int'(s)));
        hi     = (k > QTR);
        addr_a = hi ? (JW'(0) - k) : k;
        addr_b = hi ? (k - QTR) : (QTR - k);
    end

    twiddle_rom #(
        .LOG2N (LOG2N),
        .AW    (JW)
    ) u_rom (
        .clk    (clk),
        .en     (en),
        .addr_a (a1),
        .addr_b (b1),
        .data_a (da),
        .data_b (db)
    );

    assign ra = $signed(TW_W'(da));
    assign rb = $signed(TW_W'(db));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            l1      <= 1'b0;
            h1      <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            v2      <= 1'b0;
            l2      <= 1'b0;
            h2      <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
        end else if (en) begin
            v1      <= issue;
            l1      <= issue && last_j;
            h1      <= hi;
            a1      <= addr_a;
            b1      <= addr_b;
            v2      <= v1;
            l2      <= l1;
            h2      <= h1;
            o_valid <= v2;
            o_last  <= l2;
            o_re    <= v2 ? (h2 ? -ra : ra) : '0;
            o_im    <= v2 ? -rb : '0;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Self-checking bench: an N=8 and an N=256 instance checked against
// a cos/-sin golden model with random backpressure.
module tb_twiddle_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, ready_a;
    logic [3:0] stage_a;
    logic signed [11:0] re_a, im_a;
    logic valid_a, last_a, busy_a, err_a;

    logic rst_b, start_b, ready_b;
    logic [3:0] stage_b;
    logic signed [11:0] re_b, im_b;
    logic valid_b, last_b, busy_b, err_b;

    twiddle_gen #(.LOG2N(3), .TW_W(12)) u_a (
        .clk(clk), .rst_n(rst_a), .i_start(start_a),
        .i_stage(stage_a), .o_re(re_a), .o_im(im_a),
        .o_valid(valid_a), .i_ready(ready_a), .o_last(last_a),
        .o_busy(busy_a), .o_err(err_a)
    );

    twiddle_gen #(.LOG2N(8), .TW_W(12)) u_b (
        .clk(clk), .rst_n(rst_b), .i_start(start_b),
        .i_stage(stage_b), .o_re(re_b), .o_im(im_b),
        .o_valid(valid_b), .i_ready(ready_b), .o_last(last_b),
        .o_busy(busy_b), .o_err(err_b)
    );

    typedef struct {
        int re;
        int im;
        int last;
    } word_t;

    word_t qa[$];
    word_t qb[$];
    int npass = 0;
    int ntot  = 0;
    int wa = 0, wb = 0, lb = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic gold(input int lg, input int s, input int j,
                        output int re, output int im);
        int k;
        real a;
        k  = (j % (1 << s)) * (1 << (lg - 1 - s));
        a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << lg);
        re = rnd(1024.0 * $cos(a));
        im = rnd(-1024.0 * $sin(a));
    endtask

    task automatic expect_stage(input bit b, input int s);
        int lg, n, re, im;
        word_t w;
        lg = b ? 8 : 3;
        n  = 1 << (lg - 1);
        for (int j = 0; j < n; j++) begin
            gold(lg, s, j, re, im);
            w.re = re;
            w.im = im;
            w.last = (j == n - 1) ? 1 : 0;
            if (b) qb.push_back(w);
            else   qa.push_back(w);
        end
    endtask

    // Compare process: handshakes against the model queues, stability
    // under backpressure, and o_last never without o_valid.
    word_t w_a, w_b, h_a, h_b;
    bit st_a = 0, st_b = 0;

    always @(negedge clk) begin
        if (rst_a) chk("a_last_qual", int'(last_a & ~valid_a), 0);
        if (st_a) begin
            chk("a_hold_v", int'(valid_a), 1);
            chk("a_hold_re", int'(re_a), h_a.re);
            chk("a_hold_im", int'(im_a), h_a.im);
            chk("a_hold_last", int'(last_a), h_a.last);
        end
        if (rst_a && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                chk("a_extra_word", 1, 0);
            end else begin
                w_a = qa.pop_front();
                chk("a_re", int'(re_a), w_a.re);
                chk("a_im", int'(im_a), w_a.im);
                chk("a_last", int'(last_a), w_a.last);
                wa++;
            end
        end
        st_a = rst_a && valid_a && !ready_a;
        h_a.re = int'(re_a);
        h_a.im = int'(im_a);
        h_a.last = int'(last_a);

        if (rst_b) chk("b_last_qual", int'(last_b & ~valid_b), 0);
        if (st_b) begin
            chk("b_hold_v", int'(valid_b), 1);
            chk("b_hold_re", int'(re_b), h_b.re);
            chk("b_hold_im", int'(im_b), h_b.im);
            chk("b_hold_last", int'(last_b), h_b.last);
        end
        if (rst_b && valid_b && ready_b) begin
            if (qb.size() == 0) begin
                chk("b_extra_word", 1, 0);
            end else begin
                w_b = qb.pop_front();
                chk("b_re", int'(re_b), w_b.re);
                chk("b_im", int'(im_b), w_b.im);
                chk("b_last", int'(last_b), w_b.last);
                wb++;
                if (last_b) lb++;
            end
        end
        st_b = rst_b && valid_b && !ready_b;
        h_b.re = int'(re_b);
        h_b.im = int'(im_b);
        h_b.last = int'(last_b);
    end

    task automatic start_a_t(input int s, input bit acc);
        @(posedge clk);
        #1;
        start_a = 1'b1;
        stage_a = 4'(s);
        if (acc) expect_stage(0, s);
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic start_b_t(input int s);
        @(posedge clk);
        #1;
        start_b = 1'b1;
        stage_b = 4'(s);
        expect_stage(1, s);
        @(posedge clk);
        #1;
        start_b = 1'b0;
    endtask

    task automatic wait_a(input int mode);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy_a) break;
            @(posedge clk);
            #1;
            if (mode == 0)               ready_a = 1'b1;
            else if (c >= 4 && c < 9)    ready_a = 1'b0;
            else                         ready_a = 1'($urandom % 2);
        end
        chk("a_done", int'(busy_a), 0);
        chk("a_qempty", qa.size(), 0);
        #1;
        ready_a = 1'b1;
    endtask

    task automatic wait_b();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy_b) break;
            @(posedge clk);
            #1;
            ready_b = 1'($urandom % 2);
        end
        chk("b_done", int'(busy_b), 0);
        chk("b_qempty", qb.size(), 0);
        #1;
        ready_b = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int re, im, w0, l0;
        rst_a = 0; start_a = 0; stage_a = 0; ready_a = 1;
        rst_b = 0; start_b = 0; stage_b = 0; ready_b = 1;

        gold(3, 2, 1, re, im);
        chk("m_8_1_re", re, 724);
        chk("m_8_1_im", im, -724);
        gold(3, 2, 3, re, im);
        chk("m_8_3_re", re, -724);
        chk("m_8_3_im", im, -724);
        gold(3, 1, 1, re, im);
        chk("m_s1_re", re, 0);
        chk("m_s1_im", im, -1024);
        gold(8, 7, 96, re, im);
        chk("m_256_96_re", re, -724);
        chk("m_256_96_im", im, -724);

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1;
        rst_b = 1;
        @(negedge clk);
        chk("rst_valid", int'(valid_a | valid_b), 0);
        chk("rst_last", int'(last_a | last_b), 0);
        chk("rst_busy", int'(busy_a | busy_b), 0);
        chk("rst_err", int'(err_a | err_b), 0);
        chk("rst_re", int'(re_a), 0);
        chk("rst_im", int'(im_b), 0);

        // 1: stage 2, exact latency and literal words
        start_a_t(2, 1);
        @(negedge clk);
        chk("t1_busy", int'(busy_a), 1);
        chk("t1_v0", int'(valid_a), 0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_v2", int'(valid_a), 0);
        @(negedge clk);
        chk("t1_w0_v", int'(valid_a), 1);
        chk("t1_w0_re", int'(re_a), 1024);
        chk("t1_w0_im", int'(im_a), 0);
        chk("t1_w0_l", int'(last_a), 0);
        @(negedge clk);
        chk("t1_w1_re", int'(re_a), 724);
        chk("t1_w1_im", int'(im_a), -724);
        @(negedge clk);
        chk("t1_w2_re", int'(re_a), 0);
        chk("t1_w2_im", int'(im_a), -1024);
        @(negedge clk);
        chk("t1_w3_re", int'(re_a), -724);
        chk("t1_w3_im", int'(im_a), -724);
        chk("t1_w3_l", int'(last_a), 1);
        @(negedge clk);
        chk("t1_busy_end", int'(busy_a), 0);
        chk("t1_v_end", int'(valid_a), 0);

        // 2: stages 0 and 1
        for (int s = 0; s < 2; s++) begin
            w0 = wa;
            start_a_t(s, 1);
            wait_a(0);
            chk("t2_nwords", wa - w0, 4);
        end

        // 3: stage 2 under random backpressure
        w0 = wa;
        start_a_t(2, 1);
        wait_a(1);
        chk("t3_nwords", wa - w0, 4);

        // 4: invalid stage, then a start ignored during RUN
        start_a_t(3, 0);
        @(negedge clk);
        chk("t4_err", int'(err_a), 1);
        chk("t4_busy", int'(busy_a), 0);
        @(negedge clk);
        chk("t4_err_off", int'(err_a), 0);
        repeat (4) @(negedge clk);
        chk("t4_novalid", int'(valid_a | busy_a), 0);
        w0 = wa;
        start_a_t(2, 1);
        start_a_t(1, 0);
        @(negedge clk);
        chk("t4_no_err", int'(err_a), 0);
        wait_a(0);
        chk("t4_nwords", wa - w0, 4);

        // 5: reset after the second word
        start_a_t(2, 1);
        repeat (5) @(posedge clk);
        #1;
        rst_a = 0;
        qa.delete();
        @(posedge clk);
        #1;
        rst_a = 1;
        @(negedge clk);
        chk("t5_valid", int'(valid_a), 0);
        chk("t5_last", int'(last_a), 0);
        chk("t5_busy", int'(busy_a), 0);
        chk("t5_err", int'(err_a), 0);
        chk("t5_re", int'(re_a), 0);
        chk("t5_im", int'(im_a), 0);
        repeat (3) @(negedge clk);
        chk("t5_flushed", int'(valid_a), 0);
        w0 = wa;
        start_a_t(2, 1);
        wait_a(0);
        chk("t5_nwords", wa - w0, 4);

        // 6: N=256, every stage with random backpressure
        for (int s = 0; s < 8; s++) begin
            w0 = wb;
            l0 = lb;
            start_b_t(s);
            wait_b();
            chk("t6_nwords", wb - w0, 128);
            chk("t6_nlast", lb - l0, 1);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
